// File: rtl/packet_rx_crc_check.sv
`default_nettype none
// ============================================================================
// Module   : packet_rx_crc_check
// Brief    : Serial packet receiver. Deserializes start/payload/CRC/stop
//            frames, checks the CRC-8 and the stop bit, and strobes the result.
// Revision : 1.0 - initial release
// ============================================================================
module packet_rx_crc_check #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   CRC_WIDTH  = 8,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY   = 8'h07
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  mode,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  crc_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_crc_last  = CNT_W'(CRC_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC     = 2'd2,
        ST_STOP    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [CRC_WIDTH-1:0]  r_crc;
    logic [CRC_WIDTH-1:0]  r_crc_rx;
    logic [CRC_WIDTH-1:0]  w_crc_upd;
    logic                  r_rx_valid;
    logic                  r_crc_err;
    logic                  r_frame_err;
    logic                  w_start;
    logic                  w_fb;
    logic                  w_crc_bad;
    logic                  w_valid_nxt;
    logic                  w_crc_err_nxt;
    logic                  w_frame_err_nxt;

    assign w_start   = (r_state == ST_IDLE) && enable && serial_in;
    assign w_fb      = r_crc[CRC_WIDTH-1] ^ serial_in;
    assign w_crc_upd = {r_crc[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    // Payload-only frames carry no CRC, so they can never fail the CRC check.
    assign w_crc_bad = r_mode && (r_crc_rx != r_crc);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = 1'b0;
        w_crc_err_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (serial_in) w_state_nxt = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (r_cnt == c_data_last) w_state_nxt = r_mode ? ST_CRC : ST_STOP;
                end
                ST_CRC: begin
                    if (r_cnt == c_crc_last) w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt     = ST_IDLE;
                    w_valid_nxt     = !w_crc_bad && !serial_in;
                    w_crc_err_nxt   = w_crc_bad;
                    w_frame_err_nxt = serial_in;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_crc       <= '0;
            r_crc_rx    <= '0;
            r_rx_valid  <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_valid_nxt;
            r_crc_err   <= w_crc_err_nxt;
            r_frame_err <= w_frame_err_nxt;
            if (w_valid_nxt) r_rx_data <= r_shift;
            if (enable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_mode <= mode;
                            r_cnt  <= '0;
                            r_crc  <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_shift <= {r_shift[DATA_WIDTH-2:0], serial_in};
                        r_crc   <= w_crc_upd;
                        r_cnt   <= (r_cnt == c_data_last) ? '0 : r_cnt + c_cnt_one;
                    end
                    ST_CRC: begin
                        // Computed CRC stays frozen while the transmitted one is collected.
                        r_crc_rx <= {r_crc_rx[CRC_WIDTH-2:0], serial_in};
                        r_cnt    <= r_cnt + c_cnt_one;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign crc_err   = r_crc_err;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_packet_rx_crc_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_rx_crc_check
// Brief    : Self-checking bench for packet_rx_crc_check: directed frames plus
//            randomized traffic against a cycle-indexed expectation timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_rx_crc_check;

    localparam int MAXC = 20000;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b1;
    logic        enable    = 1'b0;
    logic        mode      = 1'b0;
    logic        serial_in = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        crc_err;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected outputs per cycle index, filled in when a frame is launched.
    bit          exp_busy  [MAXC];
    bit          exp_valid [MAXC];
    bit          exp_cerr  [MAXC];
    bit          exp_ferr  [MAXC];
    logic [31:0] exp_pay   [MAXC];
    logic [31:0] model_data = '0;
    int          valid_cycles[$];

    packet_rx_crc_check #(
        .DATA_WIDTH (32),
        .CRC_WIDTH  (8),
        .CRC_POLY   (8'h07)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mode      (mode),
        .serial_in (serial_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .crc_err   (crc_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // CRC as the remainder of polynomial long division of payload*x^8 by x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input logic [31:0] d);
        logic [39:0] v;
        logic [39:0] g;
        v = {d, 8'h00};
        for (int i = 39; i >= 8; i--) begin
            if (v[i]) begin
                g = 40'h107 << (i - 8);
                v = v ^ g;
            end
        end
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp(input int from, input int upto);
        for (int c = from; c <= upto && c < MAXC; c++) begin
            exp_busy[c]  = 1'b0;
            exp_valid[c] = 1'b0;
            exp_cerr[c]  = 1'b0;
            exp_ferr[c]  = 1'b0;
        end
    endtask

    // abort_kind: 0 none, 1 enable dropped in bit abort_at, 2 reset pulsed in bit abort_at.
    task automatic send_frame(input logic [31:0] pay, input bit m, input logic [7:0] crc_tx,
                              input bit stop, input int abort_kind, input int abort_at,
                              input bit mode_noise);
        int          t0;
        int          len;
        logic [41:0] bits;
        bit          crc_ok;
        len    = m ? 42 : 34;
        t0     = cyc;
        bits   = m ? {1'b1, pay, crc_tx, stop} : {1'b1, pay, stop, 8'h00};
        crc_ok = (crc_tx == crc_ref(pay));
        for (int c = t0 + 1; c < t0 + len && c < MAXC; c++) exp_busy[c] = 1'b1;
        if (t0 + len < MAXC) begin
            exp_valid[t0+len] = (!m || crc_ok) && !stop;
            exp_cerr[t0+len]  = m && !crc_ok;
            exp_ferr[t0+len]  = stop;
            exp_pay[t0+len]   = pay;
        end
        for (int k = 0; k < len; k++) begin
            enable    = 1'b1;
            serial_in = bits[41-k];
            mode      = (k == 0 || !mode_noise) ? m : 1'($urandom);
            if (abort_kind == 1 && k == abort_at) begin
                enable = 1'b0;
                clear_exp(t0 + k + 1, t0 + len);
                next_cycle();
                serial_in = 1'b0;
                return;
            end
            if (abort_kind == 2 && k == abort_at) begin
                resetn = 1'b0;
                clear_exp(t0 + k, t0 + len);
                #1;
                check("rst_rx_data",   rx_data,        32'h0);
                check("rst_rx_valid",  32'(rx_valid),  32'h0);
                check("rst_crc_err",   32'(crc_err),   32'h0);
                check("rst_frame_err", 32'(frame_err), 32'h0);
                check("rst_busy",      32'(busy),      32'h0);
                next_cycle();
                resetn    = 1'b1;
                serial_in = 1'b0;
                return;
            end
            next_cycle();
        end
        serial_in = 1'b0;
    endtask

    task automatic strobe_pin(input string tag, input bit v, input bit ce, input bit fe,
                              input logic [31:0] d);
        @(negedge clk);
        check({tag, "_rx_valid"},  32'(rx_valid),  32'(v));
        check({tag, "_crc_err"},   32'(crc_err),   32'(ce));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
        check({tag, "_rx_data"},   rx_data,        d);
        check({tag, "_busy"},      32'(busy),      32'h0);
        next_cycle();
    endtask

    initial forever begin
        @(negedge clk);
        if (cyc < MAXC) begin
            if (!resetn) model_data = '0;
            else if (exp_valid[cyc]) model_data = exp_pay[cyc];
            if (rx_valid === 1'b1) valid_cycles.push_back(cyc);
            check("busy",      32'(busy),      32'(exp_busy[cyc]));
            check("rx_valid",  32'(rx_valid),  32'(exp_valid[cyc]));
            check("crc_err",   32'(crc_err),   32'(exp_cerr[cyc]));
            check("frame_err", 32'(frame_err), 32'(exp_ferr[cyc]));
            check("rx_data",   rx_data,        model_data);
        end
    end

    initial begin
        logic [31:0] p;
        logic [7:0]  c;
        bit          m;
        bit          st;
        int          ak;
        int          aa;
        int          len;
        int          gap;
        int          nv;

        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data",   rx_data,        32'h0);
        check("reset_rx_valid",  32'(rx_valid),  32'h0);
        check("reset_crc_err",   32'(crc_err),   32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        next_cycle();
        resetn = 1'b1;
        enable = 1'b1;
        next_cycle();
        next_cycle();

        send_frame(32'h0000_0001, 1'b1, 8'h07, 1'b0, 0, 0, 1'b0);
        strobe_pin("good_crc", 1'b1, 1'b0, 1'b0, 32'h0000_0001);
        send_frame(32'h0000_0001, 1'b1, 8'h06, 1'b0, 0, 0, 1'b0);
        strobe_pin("bad_crc", 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        send_frame(32'h0000_0000, 1'b1, 8'h00, 1'b1, 0, 0, 1'b0);
        strobe_pin("bad_stop", 1'b0, 1'b0, 1'b1, 32'h0000_0001);
        send_frame(32'hA5A5_0F0F, 1'b0, 8'h00, 1'b0, 0, 0, 1'b0);
        strobe_pin("no_crc", 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F);

        // Back-to-back frames with mode toggling after each start bit.
        send_frame(32'h1234_5678, 1'b1, crc_ref(32'h1234_5678), 1'b0, 0, 0, 1'b1);
        send_frame(32'hDEAD_BEEF, 1'b1, crc_ref(32'hDEAD_BEEF), 1'b0, 0, 0, 1'b1);
        strobe_pin("b2b", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        nv = valid_cycles.size();
        if (nv >= 2) check("b2b_spacing", 32'(valid_cycles[nv-1] - valid_cycles[nv-2]), 32'd42);
        else check("b2b_pulses", 32'(nv), 32'd2);

        send_frame(32'hCAFE_0001, 1'b1, crc_ref(32'hCAFE_0001), 1'b0, 1, 20, 1'b0);
        @(negedge clk);
        check("en_drop_busy", 32'(busy), 32'h0);
        next_cycle();
        enable = 1'b1;
        repeat (30) next_cycle();
        send_frame(32'h0BAD_F00D, 1'b1, crc_ref(32'h0BAD_F00D), 1'b0, 2, 10, 1'b0);
        repeat (3) next_cycle();

        for (int f = 0; f < 120; f++) begin
            p  = $urandom;
            m  = 1'($urandom_range(0, 1));
            c  = crc_ref(p);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            st = ($urandom_range(0, 7) == 0);
            len = m ? 42 : 34;
            case ($urandom_range(0, 19))
                0, 1:    ak = 1;
                2:       ak = 2;
                default: ak = 0;
            endcase
            aa = $urandom_range(0, len - 1);
            send_frame(p, m, c, st, ak, aa, 1'b1);
            if ($urandom_range(0, 2) != 0) begin
                gap = $urandom_range(1, 5);
                for (int i = 0; i < gap; i++) begin
                    enable    = 1'($urandom_range(0, 1));
                    serial_in = enable ? 1'b0 : 1'($urandom);
                    mode      = 1'($urandom);
                    next_cycle();
                end
                serial_in = 1'b0;
            end
        end

        enable = 1'b1;
        repeat (5) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
